// File: rtl/bcd_pkg.sv
// Shared definitions for the serial BCD adder: controller state encoding
// and the BCD digit constants used by the one-digit adder.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int         BCD_DIGIT_W = 4;
  localparam logic [4:0] BCD_MAX     = 5'd9;
  localparam logic [3:0] BCD_ADJ     = 4'd6;

endpackage

// File: rtl/bcd_digit_add.sv
// One-digit combinational BCD adder.
//   da, db : BCD digits (may be invalid, >9)
//   ci     : decimal carry in
//   dsum   : corrected result digit
//   co     : decimal carry out
//   dinv   : either input digit is greater than 9
import bcd_pkg::*;

module bcd_digit_add (
  input  logic [BCD_DIGIT_W-1:0] da,
  input  logic [BCD_DIGIT_W-1:0] db,
  input  logic                   ci,
  output logic [BCD_DIGIT_W-1:0] dsum,
  output logic                   co,
  output logic                   dinv
);

  logic [4:0] s;

  always_comb begin
    s = {1'b0, da} + {1'b0, db} + {4'b0000, ci};
    // (s + 6) mod 16 equals the low nibble of the 5-bit corrected sum
    if (s > BCD_MAX) begin
      dsum = s[3:0] + BCD_ADJ;
      co   = 1'b1;
    end else begin
      dsum = s[3:0];
      co   = 1'b0;
    end
    dinv = ({1'b0, da} > BCD_MAX) || ({1'b0, db} > BCD_MAX);
  end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Multi-digit BCD adder controller: walks a single bcd_digit_add across
// NDIGITS packed BCD digits, least-significant first, one digit per clock.
//   clk, rst : clock, synchronous active-high reset
//   start    : request, accepted in IDLE or DONE
//   a, b     : packed BCD operands, digit 0 in bits [3:0]
//   cin      : decimal carry into digit 0
//   busy     : high while digits are being processed
//   done     : one-cycle pulse when the result is published
//   sum      : registered packed BCD result
//   cout     : decimal carry out of the top digit
//   err      : some captured operand digit was greater than 9
import bcd_pkg::*;

module bcd_serial_add_ctrl #(
  parameter int NDIGITS = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [BCD_DIGIT_W*NDIGITS-1:0] a,
  input  logic [BCD_DIGIT_W*NDIGITS-1:0] b,
  input  logic                           cin,
  output logic                           busy,
  output logic                           done,
  output logic [BCD_DIGIT_W*NDIGITS-1:0] sum,
  output logic                           cout,
  output logic                           err
);

  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NDIGITS - 1);

  typedef logic [NDIGITS-1:0][BCD_DIGIT_W-1:0] vec_t;

  state_t            state;
  vec_t              wa;
  vec_t              wb;
  vec_t              wsum;
  vec_t              wsum_nxt;
  logic              carry;
  logic              werr;
  logic [IW-1:0]     idx;

  logic [BCD_DIGIT_W-1:0] dsum;
  logic                   co;
  logic                   dinv;

  bcd_digit_add u_digit (
    .da   (wa[idx]),
    .db   (wb[idx]),
    .ci   (carry),
    .dsum (dsum),
    .co   (co),
    .dinv (dinv)
  );

  // Working sum with the current digit merged in; this is what gets
  // published on the final RUN edge, so the last digit is not lost.
  always_comb begin
    wsum_nxt      = wsum;
    wsum_nxt[idx] = dsum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wa    <= '0;
      wb    <= '0;
      wsum  <= '0;
      carry <= 1'b0;
      werr  <= 1'b0;
      idx   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            wa    <= a;
            wb    <= b;
            carry <= cin;
            wsum  <= '0;
            werr  <= 1'b0;
            idx   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          wsum  <= wsum_nxt;
          carry <= co;
          werr  <= werr | dinv;
          if (idx == LAST) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            sum   <= wsum_nxt;
            cout  <= co;
            err   <= werr | dinv;
            state <= DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
module tb_bcd_serial_add_ctrl;

  localparam int N = 4;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        cin = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        busy, done, cout, err;
  logic [15:0] sum;

  logic        start1 = 1'b0;
  logic        cin1 = 1'b0;
  logic [3:0]  a1 = '0;
  logic [3:0]  b1 = '0;
  logic        busy1, done1, cout1, err1;
  logic [3:0]  sum1;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  bcd_serial_add_ctrl #(.NDIGITS(N)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .err(err)
  );

  bcd_serial_add_ctrl #(.NDIGITS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .err(err1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic c);
    exp_t       e;
    logic [4:0] s;
    logic [3:0] xd, yd;
    logic       cy;
    cy    = c;
    e.sum = '0;
    e.err = 1'b0;
    for (int i = 0; i < 4; i++) begin
      xd = x[4*i +: 4];
      yd = y[4*i +: 4];
      if (xd > 4'd9 || yd > 4'd9) e.err = 1'b1;
      s = {1'b0, xd} + {1'b0, yd} + {4'b0000, cy};
      if (s > 5'd9) begin
        s  = s + 5'd6;
        cy = 1'b1;
      end else begin
        cy = 1'b0;
      end
      e.sum[4*i +: 4] = s[3:0];
    end
    e.cout = cy;
    return e;
  endfunction

  function automatic exp_t mk(input logic [15:0] s, input logic c, input logic e);
    exp_t r;
    r.sum  = s;
    r.cout = c;
    r.err  = e;
    return r;
  endfunction

  // Scoreboard: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("sum", sum, e.sum);
        check("cout", cout, e.cout);
        check("err", err, e.err);
      end
    end
  end

  // Called at a negedge; start is sampled on the next rising edge.
  task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic ic,
                       input bit push, input exp_t e);
    a     = ia;
    b     = ib;
    cin   = ic;
    start = 1'b1;
    if (push) q.push_back(e);
  endtask

  // Checks busy for exactly N cycles then a done pulse; ends on the
  // negedge where done is high. poke>=0 pulses start mid-RUN.
  task automatic expect_run(input int poke);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i > 0) @(negedge clk);
      check("busy_run", busy, 1);
      check("done_run", done, 0);
      if (i == poke) begin
        start = 1'b1;
        a     = 16'h1111;
        b     = 16'h2222;
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    check("done_pulse", done, 1);
    check("busy_done", busy, 0);
  endtask

  task automatic op(input logic [15:0] ia, input logic [15:0] ib, input logic ic, input exp_t e);
    issue(ia, ib, ic, 1'b1, e);
    expect_run(-1);
    @(negedge clk);
    check("done_low_idle", done, 0);
    check("busy_low_idle", busy, 0);
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic        rc;

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_err", err, 0);
    check("rst_busy1", busy1, 0);
    check("rst_sum1", sum1, 0);
    rst = 1'b0;
    @(negedge clk);

    op(16'h0053, 16'h0035, 1'b1, mk(16'h0089, 1'b0, 1'b0));
    op(16'h0099, 16'h0001, 1'b0, mk(16'h0100, 1'b0, 1'b0));
    op(16'h9999, 16'h0001, 1'b0, mk(16'h0000, 1'b1, 1'b0));
    op(16'h9999, 16'h9999, 1'b1, mk(16'h9999, 1'b1, 1'b0));
    op(16'h00A0, 16'h0000, 1'b0, mk(16'h0100, 1'b0, 1'b1));
    op(16'h1234, 16'h4321, 1'b0, mk(16'h5555, 1'b0, 1'b0));

    // start mid-RUN is ignored and not queued
    issue(16'h0456, 16'h0544, 1'b0, 1'b1, mk(16'h1000, 1'b0, 1'b0));
    expect_run(1);
    @(negedge clk);
    check("poke_no_second_done", done, 0);
    check("poke_idle_busy", busy, 0);
    repeat (2) @(negedge clk);
    check("poke_still_idle", busy, 0);
    check("sum_stable_idle", sum, 16'h1000);

    // back-to-back: new start accepted in DONE
    issue(16'h0001, 16'h0002, 1'b0, 1'b1, mk(16'h0003, 1'b0, 1'b0));
    expect_run(-1);
    issue(16'h5000, 16'h5000, 1'b0, 1'b1, mk(16'h0000, 1'b1, 1'b0));
    expect_run(-1);
    @(negedge clk);
    check("b2b_done_low", done, 0);

    for (int k = 0; k < 4; k++) begin
      for (int d = 0; d < 4; d++) begin
        ra[4*d +: 4] = 4'($urandom_range(0, 9));
        rb[4*d +: 4] = 4'($urandom_range(0, 9));
      end
      rc = 1'($urandom_range(0, 1));
      op(ra, rb, rc, model(ra, rb, rc));
    end

    op(16'h1234, 16'h4321, 1'b1, mk(16'h5556, 1'b0, 1'b0));

    // reset in the second RUN cycle aborts with no done
    issue(16'h7777, 16'h1111, 1'b0, 1'b0, mk(16'h0, 1'b0, 1'b0));
    @(negedge clk);
    start = 1'b0;
    check("abort_busy_before", busy, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_sum", sum, 0);
    check("abort_cout", cout, 0);
    check("abort_err", err, 0);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("abort_no_done", done, 0);
    end

    op(16'h0053, 16'h0035, 1'b1, mk(16'h0089, 1'b0, 1'b0));

    // single-digit instance
    a1     = 4'h9;
    b1     = 4'h8;
    cin1   = 1'b0;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    check("n1_busy", busy1, 1);
    check("n1_done_early", done1, 0);
    @(negedge clk);
    check("n1_done", done1, 1);
    check("n1_sum", sum1, 4'h7);
    check("n1_cout", cout1, 1);
    check("n1_err", err1, 0);
    @(negedge clk);
    check("n1_done_low", done1, 0);

    check("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_serial_add_ctrl.md
# bcd_serial_add_ctrl

Multi-digit BCD adder controller that sequences a single-digit BCD adder across an N-digit packed operand pair, least-significant digit first, one digit per clock. It extends the team's combinational one-digit BCD adder (two 4-bit digits plus carry-in, producing a corrected digit and a decimal carry) to wide decimal operands. Upstream logic uses a start/done handshake, and the result is held until the next operation.

## Interface
- NDIGITS, default 4: number of BCD digits per operand (≥1).
- clk  in  1: single clock; all state changes on the rising edge.
- rst  in  1: synchronous reset, active-high.
- start  in  1: request; sampled only in IDLE or DONE.
- a  in  4*NDIGITS: operand A, packed BCD, digit 0 in bits [3:0].
- b  in  4*NDIGITS: operand B, same packing.
- cin  in  1: decimal carry into digit 0.
- busy  out  1: high while in RUN.
- done  out  1: one-cycle pulse, high while in DONE.
- sum  out  4*NDIGITS: registered packed BCD result.
- cout  out  1: decimal carry out of the top digit.
- err  out  1: at least one digit of the captured a or b was >9.

## Operation
- States: IDLE, RUN, DONE.
- IDLE with start=1: capture a, b and cin into working registers, set idx=0, clear the working error flag, go to RUN.
- RUN, each edge, for digit idx:
  - s = a_d + b_d + carry, computed 5 bits wide.
  - If s>9: digit = (s+6)[3:0] and carry = 1. Otherwise digit = s[3:0] and carry = 0.
  - If a_d>9 or b_d>9, set the working error flag.
  - Write the digit into the working sum at position idx, then increment idx.
- Leave RUN after the edge that processes idx=NDIGITS-1 and enter DONE.
  - On that same edge, copy the working sum to sum, the final carry to cout, and the working error flag to err.
- DONE lasts one cycle:
  - start=1: accept a new operation exactly as from IDLE and go to RUN.
  - Otherwise go to IDLE.
- start in RUN is ignored. The operation in progress completes unchanged, and the request is not queued.
- sum, cout and err change only on entry to DONE or on reset. They are stable in IDLE, RUN and DONE otherwise.
- Invalid digits use the same correction rule; the result digit is defined but not meaningful, and err flags the case.
- rst=1 on any edge, including mid-RUN:
  - State goes to IDLE; idx and all working registers are cleared.
  - Outputs: busy=0, done=0, sum=0, cout=0, err=0.
  - The aborted operation produces no done.

## Timing
- start sampled high at edge k: busy=1 from k through k+NDIGITS-1.
- done=1 after edge k+NDIGITS, and sum/cout/err update at that same edge.
- Latency from start edge to done is NDIGITS cycles. Throughput is one operation per NDIGITS+1 cycles, or NDIGITS cycles with back-to-back starts in DONE.
- Digit adder is combinational between working registers; critical path is one 5-bit add, compare and +6.
- NDIGITS=1: RUN lasts one cycle and done appears after edge k+1.
- idx width is clog2(NDIGITS) with a minimum of 1. idx never wraps; the exit condition is idx==NDIGITS-1.

## Structure
- Shared package bcd_pkg holds:
  - state typedef {IDLE, RUN, DONE};
  - BCD_DIGIT_W=4, BCD_MAX=9, BCD_ADJ=6.
- One sub-module, bcd_digit_add: combinational, with inputs da, db, ci and outputs dsum, co, dinv (digit >9).
- The controller holds the FSM, idx counter, working operand/sum registers and output registers.

## Test plan
All scenarios use NDIGITS=4 unless stated.
- a=0x0053, b=0x0035, cin=1 → done after 4 cycles, sum=0x0089, cout=0, err=0.
- a=0x0099, b=0x0001, cin=0 → sum=0x0100, cout=0. a=0x9999, b=0x0001 → sum=0x0000, cout=1.
- a=0x9999, b=0x9999, cin=1 → sum=0x9999, cout=1. busy high exactly 4 cycles, done a 1-cycle pulse.
- a=0x00A0, b=0x0000 → err=1 and digit 1 of sum=0x0 (10 corrected by +6 with carry, giving sum=0x0100). A following valid operation clears err.
- Start pulsed mid-RUN with different operands → ignored; first result unchanged. Start held in DONE → back-to-back second result NDIGITS cycles later.
- rst asserted in the 2nd RUN cycle → next edge busy=0, sum=0, no done. NDIGITS=1: 0x9+0x8 → sum=0x7, cout=1, done one cycle after start.
